// File: rtl/dca_matrix_load_sequencer.sv
// Expands one matrix-load instruction into per-row read requests, limits rows in flight,
// and queues per-row unpack info in issue order for the row-unpack stage.
module dca_matrix_load_sequencer #(
  parameter int BW_ADDR         = 32,
  parameter int BW_STRIDE_LS3   = 16,
  parameter int BW_NUM_ROW_M1   = 8,
  parameter int MATRIX_SIZE     = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BW_COL   = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
  localparam int BW_RINFO = MATRIX_SIZE + 3 + 1 + BW_NUM_ROW_M1 + 1
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [BW_ADDR-1:0]       inst_addr,
  input  logic [BW_STRIDE_LS3-1:0] inst_stride_ls3,
  input  logic [BW_NUM_ROW_M1-1:0] inst_num_row_m1,
  input  logic [BW_COL-1:0]        inst_num_col_m1,
  input  logic [2:0]               inst_addr_lsa_p3,
  input  logic                     inst_is_signed,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [BW_ADDR-1:0]       req_addr,
  output logic [7:0]               req_size_m1,
  output logic                     rinfo_valid,
  output logic [BW_RINFO-1:0]      rinfo,
  input  logic                     row_retire,
  output logic                     busy,
  output logic                     done
);

  localparam int BW_PTR = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW_CNT = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [BW_ADDR-1:0]       cur_addr_q, cur_addr_d;
  logic [BW_NUM_ROW_M1-1:0] row_idx_q, row_idx_d;
  logic [BW_PTR-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW_CNT-1:0]        cnt_q, cnt_d;
  logic                     inst_ready_q, inst_ready_d, req_valid_q, req_valid_d;
  logic                     busy_q, busy_d, done_q, done_d;

  logic [BW_STRIDE_LS3-1:0] stride_q, stride_d;
  logic [BW_NUM_ROW_M1-1:0] num_row_m1_q, num_row_m1_d;
  logic [MATRIX_SIZE-1:0]   col_mask_q, col_mask_d;
  logic [2:0]               lsa_q, lsa_d;
  logic                     is_signed_q, is_signed_d;
  logic [7:0]               size_m1_q, size_m1_d;

  logic [BW_RINFO-1:0]      fifo_mem [MAX_OUTSTANDING];

  logic [2:0]               lsa_eff;
  int                       ncol_i, bits_i;
  logic [MATRIX_SIZE-1:0]   mask_new;
  logic [7:0]               size_new;
  logic                     push, pop, last_row;
  logic                     accept;

  // Row geometry of the incoming instruction, decoded once at accept time.
  always_comb begin
    lsa_eff = (inst_addr_lsa_p3 > 3'd5) ? 3'd5 : inst_addr_lsa_p3;
    if (int'(inst_num_col_m1) > MATRIX_SIZE - 1) ncol_i = MATRIX_SIZE;
    else                                         ncol_i = int'(inst_num_col_m1) + 1;
    bits_i   = ncol_i << lsa_eff;
    size_new = 8'(((bits_i + 7) >> 3) - 1);
    mask_new = '0;
    for (int i = 0; i < MATRIX_SIZE; i++) mask_new[i] = (i < ncol_i);
  end

  assign push     = req_valid_q && req_ready;
  assign pop      = row_retire && (cnt_q != '0);
  assign last_row = (row_idx_q == num_row_m1_q);
  assign accept   = (state_q == S_IDLE) && inst_valid;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    row_idx_d    = row_idx_q;
    stride_d     = stride_q;
    num_row_m1_d = num_row_m1_q;
    col_mask_d   = col_mask_q;
    lsa_d        = lsa_q;
    is_signed_d  = is_signed_q;
    size_m1_d    = size_m1_q;
    wr_ptr_d     = wr_ptr_q + BW_PTR'(push);
    rd_ptr_d     = rd_ptr_q + BW_PTR'(pop);
    cnt_d        = cnt_q + BW_CNT'(push) - BW_CNT'(pop);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cur_addr_d   = inst_addr;
          row_idx_d    = '0;
          stride_d     = inst_stride_ls3;
          num_row_m1_d = inst_num_row_m1;
          col_mask_d   = mask_new;
          lsa_d        = lsa_eff;
          is_signed_d  = inst_is_signed;
          size_m1_d    = size_new;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (push) begin
          cur_addr_d = cur_addr_q + (BW_ADDR'(stride_q) << 3);
          row_idx_d  = row_idx_q + 1'b1;
          if (last_row) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including retires of rows already in flight.
    if (clear) begin
      state_d    = S_IDLE;
      cur_addr_d = '0;
      row_idx_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end

    inst_ready_d = (state_d == S_IDLE);
    req_valid_d  = (state_d == S_ISSUE) && (cnt_d < BW_CNT'(MAX_OUTSTANDING));
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      row_idx_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      inst_ready_q <= 1'b1;
      req_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      row_idx_q    <= row_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      inst_ready_q <= inst_ready_d;
      req_valid_q  <= req_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    stride_q     <= stride_d;
    num_row_m1_q <= num_row_m1_d;
    col_mask_q   <= col_mask_d;
    lsa_q        <= lsa_d;
    is_signed_q  <= is_signed_d;
    size_m1_q    <= size_m1_d;
    if (push) fifo_mem[wr_ptr_q] <= {col_mask_q, lsa_q, is_signed_q, row_idx_q, last_row};
  end

  assign inst_ready  = inst_ready_q;
  assign req_valid   = req_valid_q;
  assign req_addr    = cur_addr_q;
  assign req_size_m1 = size_m1_q;
  assign rinfo_valid = (cnt_q != '0);
  assign rinfo       = fifo_mem[rd_ptr_q];
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dca_matrix_load_sequencer.sv
// Bench for dca_matrix_load_sequencer: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dca_matrix_load_sequencer;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0, clear = 1'b0, inst_valid = 1'b0, inst_is_signed = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [15:0] inst_stride_ls3 = '0;
  logic [7:0]  inst_num_row_m1 = '0;
  logic [1:0]  inst_num_col_m1 = '0;
  logic [2:0]  inst_addr_lsa_p3 = '0;
  logic        req_ready = 1'b0, row_retire = 1'b0;
  logic        inst_ready, req_valid, rinfo_valid, busy, done;
  logic [31:0] req_addr;
  logic [7:0]  req_size_m1;
  logic [16:0] rinfo;

  dca_matrix_load_sequencer #(
    .BW_ADDR(32), .BW_STRIDE_LS3(16), .BW_NUM_ROW_M1(8), .MATRIX_SIZE(4), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rstnn(rstnn), .clear(clear),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_addr(inst_addr),
    .inst_stride_ls3(inst_stride_ls3), .inst_num_row_m1(inst_num_row_m1),
    .inst_num_col_m1(inst_num_col_m1), .inst_addr_lsa_p3(inst_addr_lsa_p3),
    .inst_is_signed(inst_is_signed),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size_m1(req_size_m1),
    .rinfo_valid(rinfo_valid), .rinfo(rinfo), .row_retire(row_retire),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of one instruction in flight.
  bit          m_active = 0, m_done_pend = 0;
  int          m_remaining = 0;
  logic [31:0] m_cur, m_stride_b;
  logic [7:0]  m_row, m_num_row, m_size;
  logic [3:0]  m_mask;
  logic [2:0]  m_lsa;
  logic        m_sign;
  logic [16:0] m_q[$];

  logic [31:0] log_addr[$];
  logic [7:0]  log_size[$];
  logic [16:0] log_ret[$];
  int          done_seen = 0;

  task automatic model_reset();
    m_active = 0; m_done_pend = 0; m_remaining = 0; m_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rstnn) begin
      chk("rst_inst_ready", 64'(inst_ready), 64'd1);
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_rinfo_valid", 64'(rinfo_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_req_addr", 64'(req_addr), 64'd0);
      model_reset();
    end else begin
      int  sz0, rem0, l, nc;
      bit  exp_rv;
      sz0  = m_q.size();
      rem0 = m_remaining;
      exp_rv = m_active && !m_done_pend && (rem0 > 0) && (sz0 < MAXO);
      chk("inst_ready", 64'(inst_ready), 64'(!m_active));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done_pend));
      chk("req_valid", 64'(req_valid), 64'(exp_rv));
      chk("rinfo_valid", 64'(rinfo_valid), 64'(sz0 != 0));
      if (req_valid && rem0 > 0) begin
        chk("req_addr", 64'(req_addr), 64'(m_cur));
        chk("req_size_m1", 64'(req_size_m1), 64'(m_size));
      end
      if (rinfo_valid && sz0 > 0) chk("rinfo", 64'(rinfo), 64'(m_q[0]));
      if (done) done_seen++;

      if (clear) model_reset();
      else begin
        if (row_retire && sz0 > 0) begin
          log_ret.push_back(rinfo);
          void'(m_q.pop_front());
        end
        if (req_valid && req_ready) begin
          log_addr.push_back(req_addr);
          log_size.push_back(req_size_m1);
          if (rem0 > 0) begin
            m_q.push_back({m_mask, m_lsa, m_sign, m_row, 1'(m_row == m_num_row)});
            m_cur = m_cur + m_stride_b;
            m_row = m_row + 8'd1;
            m_remaining--;
          end
        end
        if (m_done_pend) begin
          m_active = 0; m_done_pend = 0;
        end else if (m_active && rem0 == 0 && sz0 == 0) m_done_pend = 1;
        if (inst_valid && inst_ready && !m_active) begin
          l  = int'(inst_addr_lsa_p3);
          if (l > 5) l = 5;
          nc = int'(inst_num_col_m1);
          if (nc > 3) nc = 3;
          nc = nc + 1;
          m_active    = 1;
          m_remaining = int'(inst_num_row_m1) + 1;
          m_cur       = inst_addr;
          m_stride_b  = 32'(inst_stride_ls3) * 32'd8;
          m_row       = 8'd0;
          m_num_row   = inst_num_row_m1;
          m_size      = 8'((nc * (2 ** l) + 7) / 8 - 1);
          m_mask      = 4'((1 << nc) - 1);
          m_lsa       = 3'(l);
          m_sign      = inst_is_signed;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_size.delete(); log_ret.delete();
  endtask

  task automatic send(input logic [31:0] a, input logic [15:0] s, input logic [7:0] nr,
                      input logic [1:0] nc, input logic [2:0] lsa, input logic sg);
    int k;
    k = 0;
    while (!inst_ready && k < 200) begin tick(); k++; end
    if (k >= 200) chk("inst_ready_timeout", 64'd0, 64'd1);
    inst_addr = a; inst_stride_ls3 = s; inst_num_row_m1 = nr;
    inst_num_col_m1 = nc; inst_addr_lsa_p3 = lsa; inst_is_signed = sg;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin tick(); k++; end
    if (k >= budget) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int d0, k;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, k;
    repeat (2) tick();
    rstnn = 1'b1;
    tick();

    // Basic 4x4 int8 load with immediate retires.
    clear_logs(); d0 = done_seen;
    req_ready = 1'b1; row_retire = 1'b1;
    send(32'h1000, 16'd2, 8'd3, 2'd3, 3'd3, 1'b0);
    wait_idle(100);
    tick();
    chk("basic_nreq", 64'(log_addr.size()), 64'd4);
    chk("basic_nret", 64'(log_ret.size()), 64'd4);
    if (log_addr.size() == 4 && log_ret.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("basic_addr", 64'(log_addr[i]), 64'(32'h1000 + 32'(i) * 32'h10));
        chk("basic_size", 64'(log_size[i]), 64'd3);
        chk("basic_mask", 64'(log_ret[i][16:13]), 64'hF);
        chk("basic_last", 64'(log_ret[i][0]), 64'(i == 3));
      end
    end
    chk("basic_done_once", 64'(done_seen - d0), 64'd1);

    // Throttle: 8 rows, no retires until the limit is hit.
    clear_logs(); row_retire = 1'b0;
    send(32'h0, 16'd1, 8'd7, 2'd3, 3'd3, 1'b0);
    repeat (10) tick();
    chk("thr_nreq_at_limit", 64'(log_addr.size()), 64'd4);
    chk("thr_req_valid_low", 64'(req_valid), 64'd0);
    row_retire = 1'b1; tick(); row_retire = 1'b0;
    repeat (3) tick();
    chk("thr_one_release", 64'(log_addr.size()), 64'd5);
    if (log_addr.size() == 5) chk("thr_addr4", 64'(log_addr[4]), 64'h20);
    row_retire = 1'b1;
    wait_idle(100);
    chk("thr_nret", 64'(log_ret.size()), 64'd8);
    if (log_ret.size() == 8)
      for (int i = 0; i < 8; i++) chk("thr_row_idx", 64'(log_ret[i][8:1]), 64'(i));

    // Sub-byte packing, single row, signed.
    clear_logs();
    send(32'h40, 16'd0, 8'd0, 2'd2, 3'd1, 1'b1);
    wait_idle(50);
    chk("sub_nret", 64'(log_ret.size()), 64'd1);
    if (log_ret.size() == 1) begin
      chk("sub_size", 64'(log_size[0]), 64'd0);
      chk("sub_mask", 64'(log_ret[0][16:13]), 64'h7);
      chk("sub_last", 64'(log_ret[0][0]), 64'd1);
      chk("sub_signed", 64'(log_ret[0][9]), 64'd1);
    end

    // Element-width clamp.
    clear_logs();
    send(32'h80, 16'd3, 8'd0, 2'd3, 3'd7, 1'b0);
    wait_idle(50);
    if (log_ret.size() == 1) begin
      chk("clamp_size", 64'(log_size[0]), 64'd15);
      chk("clamp_lsa", 64'(log_ret[0][12:10]), 64'd5);
    end else chk("clamp_nret", 64'(log_ret.size()), 64'd1);

    // Backpressure on the request side.
    clear_logs(); req_ready = 1'b0;
    send(32'h2000, 16'd4, 8'd2, 2'd3, 3'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_addr_stable", 64'(req_addr), 64'h2000);
      chk("bp_no_push", 64'(rinfo_valid), 64'd0);
      tick();
    end
    req_ready = 1'b1;
    wait_idle(50);
    chk("bp_nreq", 64'(log_addr.size()), 64'd3);
    if (log_addr.size() == 3) begin
      chk("bp_addr2", 64'(log_addr[2]), 64'h2040);
      chk("bp_size", 64'(log_size[0]), 64'd1);
    end

    // Abort mid-issue after two rows, then a normal instruction.
    clear_logs(); row_retire = 1'b0; d0 = done_seen;
    send(32'h3000, 16'd1, 8'd5, 2'd3, 3'd3, 1'b0);
    k = 0;
    while (log_addr.size() < 2 && k < 50) begin tick(); k++; end
    req_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; row_retire = 1'b1;
    chk("abort_inst_ready", 64'(inst_ready), 64'd1);
    chk("abort_rinfo_valid", 64'(rinfo_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_nreq", 64'(log_addr.size()), 64'd2);
    repeat (3) tick();
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);
    clear_logs(); req_ready = 1'b1;
    send(32'h1000, 16'd2, 8'd3, 2'd3, 3'd3, 1'b0);
    wait_idle(100);
    tick();
    chk("post_abort_done", 64'(done_seen - d0), 64'd1);
    if (log_addr.size() == 4) chk("post_abort_addr3", 64'(log_addr[3]), 64'h1030);
    else chk("post_abort_nreq", 64'(log_addr.size()), 64'd4);

    // Async reset while draining.
    row_retire = 1'b0;
    send(32'h500, 16'd1, 8'd1, 2'd0, 3'd3, 1'b0);
    repeat (4) tick();
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_req_valid", 64'(req_valid), 64'd0);
    #2 rstnn = 1'b0;
    #1;
    chk("arst_inst_ready", 64'(inst_ready), 64'd1);
    chk("arst_req_valid", 64'(req_valid), 64'd0);
    chk("arst_rinfo_valid", 64'(rinfo_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_req_addr", 64'(req_addr), 64'd0);
    tick();
    rstnn = 1'b1; row_retire = 1'b1;
    tick();
    clear_logs();
    send(32'h600, 16'd1, 8'd1, 2'd1, 3'd4, 1'b0);
    wait_idle(50);
    chk("post_rst_nreq", 64'(log_addr.size()), 64'd2);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
